// File: rtl/irq_arbiter_if.sv
// Signal bundle between the interrupt sources/CPU side and irq_arbiter.
// The master drives the sources, mask writes and reti; the slave (the arbiter) drives the rest.
interface irq_arbiter_if;
    logic [7:0] i_irq_src;
    logic       i_mask_we;
    logic [7:0] i_mask_wdata;
    logic       i_reti;
    logic       o_IRQ;
    logic [4:0] o_ISR_addr;
    logic [7:0] o_pending;
    logic [7:0] o_in_service;
    logic [7:0] o_mask;
    logic       o_busy;

    modport master (
        output i_irq_src, i_mask_we, i_mask_wdata, i_reti,
        input  o_IRQ, o_ISR_addr, o_pending, o_in_service, o_mask, o_busy
    );

    modport slave (
        input  i_irq_src, i_mask_we, i_mask_wdata, i_reti,
        output o_IRQ, o_ISR_addr, o_pending, o_in_service, o_mask, o_busy
    );
endinterface

// File: rtl/irq_arbiter.sv
// 8-source edge-latched interrupt arbiter with a fixed priority (bit 0 highest) and a one-cycle IRQ pulse.
// Define IRQ_PREEMPT_EN to let a higher-priority source nest on top of the ISR currently running.
module irq_arbiter (
    input  logic          clk,
    input  logic          rst,
    irq_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GRANT, SERVICE} state_t;

    state_t     state, state_nxt;
    logic [7:0] src_q;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic [7:0] mask;
    logic [4:0] isr_addr;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] win_onehot;
    logic [2:0] win_idx;
    logic [7:0] svc_low;
    logic [7:0] svc_below;
    logic       grant;
    logic       retire;

    assign rise      = bus.i_irq_src & ~src_q;
    assign eligible  = pending & ~mask;
    // Isolate the lowest in-service bit; everything below it may preempt.
    assign svc_low   = in_service & (~in_service + 8'd1);
    assign svc_below = svc_low - 8'd1;

    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx    = 3'(i);
                win_onehot = 8'd1 << i;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_nxt = state;
        grant     = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant     = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: state_nxt = SERVICE;
            SERVICE: begin
                if (bus.i_reti && |in_service) begin
                    retire = 1'b1;
                    if ((in_service & ~svc_low) == 8'h00) state_nxt = IDLE;
                end
`ifdef IRQ_PREEMPT_EN
                else if (|(eligible & svc_below)) begin
                    grant     = 1'b1;
                    state_nxt = GRANT;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= 8'hFF;
            isr_addr   <= '0;
        end else begin
            src_q      <= bus.i_irq_src;
            // A fresh edge wins over the grant clearing the same bit.
            pending    <= (pending & ~(grant ? win_onehot : 8'h00)) | rise;
            in_service <= (in_service & ~(retire ? svc_low : 8'h00)) | (grant ? win_onehot : 8'h00);
            if (bus.i_mask_we) mask <= bus.i_mask_wdata;
            if (grant) isr_addr <= {2'b00, win_idx};
        end
    end

    assign bus.o_IRQ        = (state == GRANT);
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_ISR_addr   = isr_addr;
    assign bus.o_pending    = pending;
    assign bus.o_in_service = in_service;
    assign bus.o_mask       = mask;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: a reference model queues each expected grant, a monitor checks every cycle.
// Directed scenarios first, then randomized sources, mask writes, reti pulses and resets.
module tb_irq_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_arbiter_if bus();
    irq_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] addr;
        logic [7:0] in_service;
        logic [7:0] pending;
    } grant_t;

    grant_t     exp_q[$];
    logic [7:0] m_pending, m_in_service, m_mask, m_prev;
    logic       m_granting;
    logic [4:0] m_addr;
    bit         m_valid = 1'b0;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] m_rise, m_elig, m_nxt;
        int g;
        if (rst) begin
            m_pending = '0; m_in_service = '0; m_mask = 8'hFF; m_prev = '0;
            m_granting = 1'b0; m_addr = '0; m_valid = 1'b1;
        end else begin
            m_rise = bus.i_irq_src & ~m_prev;
            m_elig = m_pending & ~m_mask;
            g = -1;
            if (m_granting) begin
                // request cycle: nothing is decided
            end else if (m_in_service == 8'h00) begin
                if (m_elig != 8'h00) g = lowest(m_elig);
            end else if (bus.i_reti) begin
                m_in_service[lowest(m_in_service)] = 1'b0;
            end
`ifdef IRQ_PREEMPT_EN
            else if (lowest(m_elig) < lowest(m_in_service)) begin
                g = lowest(m_elig);
            end
`endif
            m_nxt = m_pending;
            if (g >= 0) m_nxt[g] = 1'b0;
            m_pending = m_nxt | m_rise;
            if (g >= 0) begin
                m_in_service[g] = 1'b1;
                m_addr = 5'(g);
                exp_q.push_back('{5'(g), m_in_service, m_pending});
            end
            m_granting = (g >= 0);
            if (bus.i_mask_we) m_mask = bus.i_mask_wdata;
            m_prev = bus.i_irq_src;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        grant_t e;
        if (m_valid) begin
            check("irq",        32'(bus.o_IRQ),        32'(m_granting));
            check("busy",       32'(bus.o_busy),       32'(m_granting || (m_in_service != 8'h00)));
            check("pending",    32'(bus.o_pending),    32'(m_pending));
            check("in_service", 32'(bus.o_in_service), 32'(m_in_service));
            check("mask",       32'(bus.o_mask),       32'(m_mask));
            check("isr_addr",   32'(bus.o_ISR_addr),   32'(m_addr));
            if (bus.o_IRQ) begin
                if (exp_q.size() == 0) begin
                    check("irq_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_addr",       32'(bus.o_ISR_addr),   32'(e.addr));
                    check("grant_in_service", 32'(bus.o_in_service), 32'(e.in_service));
                    check("grant_pending",    32'(bus.o_pending),    32'(e.pending));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.i_mask_we    = 1'b1;
        bus.i_mask_wdata = m;
        cyc();
        bus.i_mask_we    = 1'b0;
    endtask

    task automatic pulse_reti();
        bus.i_reti = 1'b1;
        cyc();
        bus.i_reti = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles, input logic [4:0] addr, input string name,
                            input bit rst_in_grant = 1'b0);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (bus.o_IRQ) begin
                seen = 1'b1;
                check(name, 32'(bus.o_ISR_addr), 32'(addr));
                if (rst_in_grant) rst = 1'b1;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_irq"},        32'(bus.o_IRQ),        32'd0);
        check({name, "_addr"},       32'(bus.o_ISR_addr),   32'd0);
        check({name, "_pending"},    32'(bus.o_pending),    32'd0);
        check({name, "_in_service"}, 32'(bus.o_in_service), 32'd0);
        check({name, "_mask"},       32'(bus.o_mask),       32'hFF);
        check({name, "_busy"},       32'(bus.o_busy),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.i_irq_src = '0; bus.i_mask_we = 1'b0; bus.i_mask_wdata = '0; bus.i_reti = 1'b0;
        cyc(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // single source, latency and vector
        write_mask(8'h00);
        bus.i_irq_src[3] = 1'b1;
        wait_irq(3, 5'd3, "single_addr");
        check("single_in_service", 32'(bus.o_in_service), 32'h08);
        check("single_pending",    32'(bus.o_pending),    32'h00);
        bus.i_irq_src = '0;
        pulse_reti();
        cyc(2);

        // two sources on the same edge; reti coincides with an eligible source
        bus.i_irq_src = 8'h24;
        wait_irq(3, 5'd2, "pair_first");
        bus.i_irq_src = '0;
        pulse_reti();
        wait_irq(3, 5'd5, "pair_second");
        pulse_reti();
        cyc(2);

        // masked source pends without a request until unmasked
        write_mask(8'h10);
        bus.i_irq_src[4] = 1'b1;
        cyc(2);
        check("masked_pending", 32'(bus.o_pending), 32'h10);
        check("masked_busy",    32'(bus.o_busy),    32'd0);
        bus.i_irq_src = '0;
        write_mask(8'h00);
        wait_irq(2, 5'd4, "unmasked_addr");
        pulse_reti();
        cyc(2);

        // re-edge of the source being serviced is granted again after reti
        bus.i_irq_src[3] = 1'b1;
        wait_irq(3, 5'd3, "reedge_first");
        bus.i_irq_src[3] = 1'b0;
        cyc();
        bus.i_irq_src[3] = 1'b1;
        cyc(2);
        check("reedge_pending", 32'(bus.o_pending), 32'h08);
        bus.i_irq_src = '0;
        pulse_reti();
        wait_irq(3, 5'd3, "reedge_second");
        pulse_reti();
        cyc(2);

        // higher priority source arrives while index 6 is in service
        bus.i_irq_src[6] = 1'b1;
        wait_irq(3, 5'd6, "nest_outer");
        bus.i_irq_src[1] = 1'b1;
`ifdef IRQ_PREEMPT_EN
        wait_irq(3, 5'd1, "nest_inner");
        check("nest_in_service_both", 32'(bus.o_in_service), 32'h42);
        pulse_reti();
        check("nest_in_service_after_reti", 32'(bus.o_in_service), 32'h40);
        pulse_reti();
`else
        cyc(4);
        check("nest_held_in_service", 32'(bus.o_in_service), 32'h40);
        pulse_reti();
        wait_irq(3, 5'd1, "nest_after_reti");
        pulse_reti();
`endif
        bus.i_irq_src = '0;
        cyc(2);

        // mask write in the grant cycle: grant still uses the old mask
        bus.i_irq_src[0] = 1'b1;
        cyc();
        write_mask(8'hFF);
        wait_irq(2, 5'd0, "mask_race_addr");
        bus.i_irq_src = '0;
        pulse_reti();
        write_mask(8'h00);
        cyc(2);

        // new edge and grant-clear on the same pending bit: set wins
        write_mask(8'hFF);
        bus.i_irq_src[1] = 1'b1;
        cyc();
        bus.i_irq_src[1] = 1'b0;
        cyc();
        write_mask(8'h00);
        bus.i_irq_src[1] = 1'b1;
        wait_irq(2, 5'd1, "set_wins_addr");
        check("set_wins_pending", 32'(bus.o_pending), 32'h02);
        bus.i_irq_src = '0;
        pulse_reti();
        wait_irq(3, 5'd1, "set_wins_regrant");
        pulse_reti();
        cyc(2);

        // stray reti in IDLE
        pulse_reti();
        check("stray_reti_busy",       32'(bus.o_busy),       32'd0);
        check("stray_reti_in_service", 32'(bus.o_in_service), 32'd0);

        // reset in GRANT, then source held through reset pends right after
        bus.i_irq_src[2] = 1'b1;
        wait_irq(3, 5'd2, "rst_grant_addr", 1'b1);
        rst = 1'b0;
        check_reset_outputs("rst_in_grant");
        cyc();
        check("held_src_pending", 32'(bus.o_pending), 32'h04);

        // reset in SERVICE
        write_mask(8'h00);
        wait_irq(3, 5'd2, "rst_service_addr");
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_outputs("rst_in_service");
        bus.i_irq_src = '0;
        cyc(2);

        // randomized traffic
        write_mask(8'h00);
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(15) == 0) bus.i_irq_src[b] = ~bus.i_irq_src[b];
            bus.i_mask_we    = ($urandom_range(31) == 0);
            bus.i_mask_wdata = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255));
            bus.i_reti       = ((m_in_service != 8'h00) && ($urandom_range(3) == 0)) ||
                               ($urandom_range(63) == 0);
            rst              = ($urandom_range(299) == 0);
            cyc();
        end

        // drain everything outstanding
        rst = 1'b0;
        bus.i_irq_src = '0;
        bus.i_mask_we = 1'b0;
        write_mask(8'hFF);
        for (int n = 0; n < 40; n++) begin
            bus.i_reti = (m_in_service != 8'h00);
            cyc();
        end
        bus.i_reti = 1'b0;
        cyc(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
